// File: rtl/whac_pkg.sv
// Shared types and constants for the whack-a-mole round scheduler.
package whac_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PICK    = 3'd1,
    S_ARMED   = 3'd2,
    S_EXPIRED = 3'd3,
    S_OVER    = 3'd4
  } state_t;

  localparam int N_MOLES = 18;
  localparam int IDX_W   = 5;
  localparam int MS_W    = 11;

  localparam logic [1:0]      LIVES_INIT   = 2'd3;
  localparam logic [MS_W-1:0] WINDOW_MS_L1 = 11'd1500;
  localparam logic [MS_W-1:0] WINDOW_MS_L2 = 11'd1000;
  localparam logic [MS_W-1:0] WINDOW_MS_L3 = 11'd600;

  function automatic logic [MS_W-1:0] window_ms(input logic [1:0] level);
    case (level)
      2'd1:    return WINDOW_MS_L1;
      2'd2:    return WINDOW_MS_L2;
      default: return WINDOW_MS_L3;
    endcase
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, x^16+x^14+x^13+x^11+1, right-shifting form.
module lfsr16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] seed,
  output logic [15:0] value
);

  logic [15:0] r_value;
  logic        w_fb;

  assign w_fb  = r_value[0] ^ r_value[2] ^ r_value[3] ^ r_value[5];
  assign value = r_value;

  always_ff @(posedge clk) begin
    if (rst) r_value <= seed;
    else     r_value <= {w_fb, r_value[15:1]};
  end

endmodule

// File: rtl/mole_round_scheduler.sv
// Picks the next mole, times its hit window in ms ticks, and tracks lives/game over.
module mole_round_scheduler
  import whac_pkg::*;
#(
  parameter int          TICKS_PER_MS = 50000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               new_game,
  input  logic [1:0]         level_number,
  input  logic               ready_for_mole,
  input  logic               timeout_start,
  input  logic               hit,
  output logic [N_MOLES-1:0] led_number,
  output logic               timeout,
  output logic [1:0]         lives,
  output logic               game_over
);

  localparam int             PW         = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam logic [PW-1:0]  PRESC_LAST = PW'(TICKS_PER_MS - 1);

  state_t             r_state,     w_state_nxt;
  logic [N_MOLES-1:0] r_led,       w_led_nxt;
  logic               r_timeout,   w_timeout_nxt;
  logic [1:0]         r_lives,     w_lives_nxt;
  logic [1:0]         r_level,     w_level_nxt;
  logic               r_game_over, w_game_over_nxt;
  logic [IDX_W-1:0]   r_prev,      w_prev_nxt;
  logic [MS_W-1:0]    r_ms,        w_ms_nxt;
  logic [PW-1:0]      r_presc,     w_presc_nxt;

  logic [15:0]        w_lfsr;
  logic               w_unused_lfsr;
  logic [IDX_W-1:0]   w_idx_raw, w_idx_fold, w_idx;
  logic               w_window, w_tick, w_expire;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (LFSR_SEED),
    .value (w_lfsr)
  );

  assign w_unused_lfsr = ^w_lfsr[15:IDX_W];

  // Fold 0..31 into 0..17, then step past the previous mole so it never repeats.
  assign w_idx_raw  = w_lfsr[IDX_W-1:0];
  assign w_idx_fold = (w_idx_raw >= IDX_W'(N_MOLES)) ? w_idx_raw - IDX_W'(N_MOLES) : w_idx_raw;
  assign w_idx      = (w_idx_fold != r_prev)                ? w_idx_fold :
                      (w_idx_fold == IDX_W'(N_MOLES - 1))   ? '0 : w_idx_fold + IDX_W'(1);

  // PICK is the first cycle of the window, so it counts exactly like ARMED.
  assign w_window = (r_state == S_PICK) || (r_state == S_ARMED);
  assign w_tick   = w_window && timeout_start && (r_presc == PRESC_LAST);
  assign w_expire = w_tick && (r_ms == MS_W'(1));

  always_comb begin
    w_state_nxt     = r_state;
    w_led_nxt       = r_led;
    w_timeout_nxt   = r_timeout;
    w_lives_nxt     = r_lives;
    w_level_nxt     = r_level;
    w_game_over_nxt = r_game_over;
    w_prev_nxt      = r_prev;
    w_ms_nxt        = r_ms;
    w_presc_nxt     = r_presc;
    if (new_game) begin
      w_state_nxt     = S_IDLE;
      w_level_nxt     = level_number;
      w_lives_nxt     = LIVES_INIT;
      w_game_over_nxt = 1'b0;
      w_led_nxt       = '0;
      w_timeout_nxt   = 1'b0;
      w_ms_nxt        = '0;
      w_presc_nxt     = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ready_for_mole && (r_level != 2'd0) && !r_game_over) begin
            w_state_nxt   = S_PICK;
            w_led_nxt     = N_MOLES'(1) << w_idx;
            w_prev_nxt    = w_idx;
            w_timeout_nxt = 1'b1;
            w_ms_nxt      = window_ms(r_level);
            w_presc_nxt   = '0;
          end
        end
        S_PICK, S_ARMED: begin
          w_state_nxt = S_ARMED;
          if (timeout_start && hit) begin
            w_led_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else if (timeout_start) begin
            if (w_tick) begin
              w_presc_nxt = '0;
              w_ms_nxt    = r_ms - MS_W'(1);
            end else begin
              w_presc_nxt = r_presc + PW'(1);
            end
            if (w_expire) begin
              w_timeout_nxt = 1'b0;
              w_led_nxt     = '0;
              w_state_nxt   = S_EXPIRED;
            end
          end
        end
        S_EXPIRED: begin
          w_lives_nxt = (r_lives == 2'd0) ? 2'd0 : r_lives - 2'd1;
          if (w_lives_nxt == 2'd0) begin
            w_state_nxt     = S_OVER;
            w_game_over_nxt = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
        S_OVER: begin
          w_led_nxt     = '0;
          w_timeout_nxt = 1'b0;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_led       <= '0;
      r_timeout   <= 1'b0;
      r_lives     <= LIVES_INIT;
      r_level     <= 2'd0;
      r_game_over <= 1'b0;
      r_prev      <= '0;
      r_ms        <= '0;
      r_presc     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_led       <= w_led_nxt;
      r_timeout   <= w_timeout_nxt;
      r_lives     <= w_lives_nxt;
      r_level     <= w_level_nxt;
      r_game_over <= w_game_over_nxt;
      r_prev      <= w_prev_nxt;
      r_ms        <= w_ms_nxt;
      r_presc     <= w_presc_nxt;
    end
  end

  assign led_number = r_led;
  assign timeout    = r_timeout;
  assign lives      = r_lives;
  assign game_over  = r_game_over;

endmodule

// File: tb/tb_mole_round_scheduler.sv
// Bench for mole_round_scheduler: directed scenarios plus random traffic against a cycle-level game model.
`timescale 1ns/1ps
module tb_mole_round_scheduler;

  localparam int          TPM  = 2;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int M_IDLE = 0, M_WIN = 1, M_MISS = 2, M_OVER = 3;

  logic        clk = 1'b0;
  logic        rst, new_game, ready_for_mole, timeout_start, hit;
  logic [1:0]  level_number;
  logic [17:0] led_number;
  logic        timeout;
  logic [1:0]  lives;
  logic        game_over;

  int checks   = 0;
  int failures = 0;

  int unsigned m_lfsr;
  int          m_mode, m_lives, m_lvl, m_prev, m_rem;
  logic [17:0] m_led;
  logic        m_to, m_go;

  logic [17:0] prev_led;
  int          fall;

  always #5 clk = ~clk;

  mole_round_scheduler #(.TICKS_PER_MS(TPM), .LFSR_SEED(SEED)) dut (
    .clk            (clk),
    .rst            (rst),
    .new_game       (new_game),
    .level_number   (level_number),
    .ready_for_mole (ready_for_mole),
    .timeout_start  (timeout_start),
    .hit            (hit),
    .led_number     (led_number),
    .timeout        (timeout),
    .lives          (lives),
    .game_over      (game_over)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int win_cycles(input int lvl);
    case (lvl)
      1:       return 1500 * TPM;
      2:       return 1000 * TPM;
      default: return 600 * TPM;
    endcase
  endfunction

  // Game rules applied once per rising edge to the inputs present at that edge.
  task automatic model_edge();
    int idx;
    int unsigned cur;
    if (rst) begin
      m_lfsr = SEED; m_mode = M_IDLE; m_led = '0; m_to = 1'b0; m_lives = 3;
      m_go = 1'b0; m_lvl = 0; m_prev = 0; m_rem = 0;
      return;
    end
    cur    = m_lfsr;
    m_lfsr = (cur >> 1) | (((cur ^ (cur >> 2) ^ (cur >> 3) ^ (cur >> 5)) & 1) << 15);
    if (new_game) begin
      m_lvl = level_number; m_lives = 3; m_go = 1'b0; m_led = '0; m_to = 1'b0; m_mode = M_IDLE;
      return;
    end
    case (m_mode)
      M_IDLE: if (ready_for_mole && m_lvl != 0 && !m_go) begin
        idx = (cur & 31) % 18;
        if (idx == m_prev) idx = (idx + 1) % 18;
        m_prev = idx;
        m_led  = 18'(1) << idx;
        m_to   = 1'b1;
        m_rem  = win_cycles(m_lvl);
        m_mode = M_WIN;
      end
      M_WIN: if (timeout_start && hit) begin
        m_led = '0; m_mode = M_IDLE;
      end else if (timeout_start) begin
        m_rem--;
        if (m_rem == 0) begin m_to = 1'b0; m_led = '0; m_mode = M_MISS; end
      end
      M_MISS: begin
        if (m_lives > 0) m_lives--;
        if (m_lives == 0) begin m_go = 1'b1; m_mode = M_OVER; end
        else m_mode = M_IDLE;
      end
      default: ;
    endcase
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    chk("led_number", 32'(led_number), 32'(m_led));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("lives", 32'(lives), m_lives);
    chk("game_over", 32'(game_over), 32'(m_go));
  endtask

  initial begin
    rst = 1'b1; new_game = 1'b0; ready_for_mole = 1'b0; timeout_start = 1'b0;
    hit = 1'b0; level_number = 2'd0;
    step(); step();
    chk("reset_led", 32'(led_number), 0);
    chk("reset_lives", 32'(lives), 3);
    rst = 1'b0; step();

    // first mole appears one cycle after the request
    new_game = 1'b1; level_number = 2'd1; step(); new_game = 1'b0;
    ready_for_mole = 1'b1; step(); ready_for_mole = 1'b0;
    chk("arm_onehot", $countones(led_number), 1);
    chk("arm_timeout", 32'(timeout), 1);
    chk("arm_lives", 32'(lives), 3);
    timeout_start = 1'b1; hit = 1'b1; step(); hit = 1'b0;

    // hard level window, level input changed afterwards must not matter
    new_game = 1'b1; level_number = 2'd3; step(); new_game = 1'b0; level_number = 2'd1;
    ready_for_mole = 1'b1; step(); ready_for_mole = 1'b0;
    fall = 0;
    for (int k = 1; k <= 1300 && fall == 0; k++) begin
      step();
      if (timeout === 1'b0) fall = k;
    end
    chk("l3_window_cycles", fall, 1200);
    chk("l3_led_cleared", 32'(led_number), 0);
    step();
    chk("l3_lives_after_miss", 32'(lives), 2);

    // reset in the middle of a window
    ready_for_mole = 1'b1; step(); ready_for_mole = 1'b0;
    repeat (200) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_mid_led", 32'(led_number), 0);
    chk("rst_mid_timeout", 32'(timeout), 0);
    chk("rst_mid_lives", 32'(lives), 3);

    // hit on the same cycle the window runs out
    new_game = 1'b1; level_number = 2'd3; step(); new_game = 1'b0;
    ready_for_mole = 1'b1; step(); ready_for_mole = 1'b0;
    repeat (1199) step();
    hit = 1'b1; step(); hit = 1'b0;
    chk("hit_at_expiry_led", 32'(led_number), 0);
    chk("hit_at_expiry_lives", 32'(lives), 3);
    chk("hit_at_expiry_timeout", 32'(timeout), 1);
    ready_for_mole = 1'b1; step(); ready_for_mole = 1'b0;
    chk("rearm_after_hit", $countones(led_number), 1);
    prev_led = led_number;
    hit = 1'b1; step(); hit = 1'b0;

    // 200 picks: always one-hot, never the previous mole
    for (int p = 0; p < 200; p++) begin
      ready_for_mole = 1'b1; step(); ready_for_mole = 1'b0;
      chk("pick_onehot", $countones(led_number), 1);
      chk("pick_repeat", 32'(led_number == prev_led), 0);
      prev_led = led_number;
      repeat ($urandom_range(0, 3)) step();
      hit = 1'b1; step(); hit = 1'b0;
    end

    // three misses end the game
    for (int m = 0; m < 3; m++) begin
      ready_for_mole = 1'b1; step(); ready_for_mole = 1'b0;
      fall = 0;
      for (int k = 1; k <= 1300 && fall == 0; k++) begin
        step();
        if (timeout === 1'b0) fall = k;
      end
      chk("miss_window_cycles", fall, 1200);
      step();
    end
    chk("over_lives", 32'(lives), 0);
    chk("over_flag", 32'(game_over), 1);
    ready_for_mole = 1'b1; step(); ready_for_mole = 1'b0;
    chk("over_ignores_ready", 32'(led_number), 0);
    new_game = 1'b1; level_number = 2'd2; step(); new_game = 1'b0;
    chk("new_game_lives", 32'(lives), 3);
    chk("new_game_clears_over", 32'(game_over), 0);

    // random traffic
    for (int c = 0; c < 4000; c++) begin
      rst            = ($urandom_range(0, 499) == 0);
      new_game       = ($urandom_range(0, 149) == 0);
      level_number   = 2'($urandom_range(0, 3));
      ready_for_mole = ($urandom_range(0, 7) == 0);
      timeout_start  = ($urandom_range(0, 7) != 0);
      hit            = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mole_round_scheduler.md
MOLE_ROUND_SCHEDULER -- requirements
Module: mole_round_scheduler

Interface
REQ-001 Param TICKS_PER_MS, default 50000, meaning clk cycles per 1 ms tick.
REQ-002 Param LFSR_SEED, default 16'hACE1, meaning LFSR value loaded on reset (nonzero).
REQ-003 Port clk  in  1  meaning the single clock, rising-edge.
REQ-004 Port rst  in  1  meaning reset, synchronous, active-high.
REQ-005 Port new_game  in  1  meaning 1-cycle pulse that latches level and restores lives.
REQ-006 Port level_number  in  2  meaning 0 = no level, 1..3 = easy/medium/hard.
REQ-007 Port ready_for_mole  in  1  meaning 1-cycle request for a new mole.
REQ-008 Port timeout_start  in  1  meaning window-active qualifier; high while the game FSM waits for a hit.
REQ-009 Port hit  in  1  meaning correct switch hit on the current mole.
REQ-010 Port led_number  out  18  meaning one-hot active mole, or 0.
REQ-011 Port timeout  out  1  meaning 1 = time remaining, 0 = expired/idle.
REQ-012 Port lives  out  2  meaning lives remaining.
REQ-013 Port game_over  out  1  meaning lives exhausted.

Function
REQ-014 Five states SHALL exist: IDLE, PICK, ARMED, EXPIRED, OVER.
REQ-015 A 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) SHALL advance every cycle outside reset.
REQ-016 new_game in any state SHALL latch level_number, set lives=3, clear game_over, clear led_number, and enter IDLE.
REQ-017 In IDLE, ready_for_mole with latched level != 0 and game_over=0 SHALL enter PICK; otherwise it SHALL be ignored.
REQ-018 PICK SHALL compute idx = lfsr[4:0], minus 18 if >= 18; if idx equals the previous idx, then idx+1 wrapping 17->0.
REQ-019 led_number SHALL be one-hot at idx and timeout SHALL be 1 on the cycle after ready_for_mole; total latency is 1 cycle, and PICK is registered in the same edge.
REQ-020 Window ms counter SHALL load 1500/1000/600 for levels 1/2/3 on entry to ARMED.
REQ-021 The ms counter SHALL decrement once per TICKS_PER_MS cycles, and only while timeout_start=1.
REQ-022 The prescaler SHALL clear on ARMED entry.
REQ-023 In ARMED, hit=1 with timeout_start=1 SHALL clear led_number and enter IDLE with timeout held 1 and lives unchanged.
REQ-024 When the ms counter reaches 0, the block SHALL clear timeout and led_number and enter EXPIRED.
REQ-025 If hit and expiry occur in the same cycle, hit SHALL win.
REQ-026 EXPIRED (1 cycle) SHALL decrement lives, saturating at 0.
REQ-027 From EXPIRED, the block SHALL enter OVER if the new lives = 0, else enter IDLE.
REQ-028 OVER SHALL hold game_over=1, led_number=0, timeout=0, and ignore everything except new_game and rst.
REQ-029 ready_for_mole while in ARMED SHALL be ignored, with no re-pick and no counter reload.
REQ-030 level_number changes SHALL have no effect until the next new_game.

Reset
REQ-031 rst SHALL force IDLE, led_number=0, timeout=0, lives=3, game_over=0, latched level=0, prev idx=0, counters=0, and LFSR=LFSR_SEED.
REQ-032 rst SHALL take priority over new_game and all other inputs in the same cycle.
REQ-033 rst mid-ARMED SHALL drop the mole within 1 cycle.

Structure
REQ-034 Package whac_pkg SHALL hold the state enum, N_MOLES=18, LIVES_INIT=3, and WINDOW_MS_L1/L2/L3.
REQ-035 The LFSR SHALL be sub-module lfsr16, with ports clk, rst, seed, and value.

Verification (TICKS_PER_MS=2)
REQ-036 rst, then new_game with level 1, then ready_for_mole -> next cycle led_number one-hot, timeout=1, lives=3.
REQ-037 Level 3 armed, timeout_start=1 held -> timeout falls exactly 1200 cycles after arming, led_number=0, lives 3->2.
REQ-038 Three consecutive misses -> lives 0, game_over=1; ready_for_mole then ignored; new_game restores lives=3 and game_over=0.
REQ-039 Hit on the same cycle the counter reaches 0 -> led_number cleared, lives unchanged, state IDLE.
REQ-040 Over 200 picks -> led_number always one-hot within bits 0..17, never equal to the previous pick.
REQ-041 rst asserted mid-ARMED (counter=500) -> next cycle led_number=0, timeout=0, lives=3.
